// File: rtl/bp_pkg.sv
// Shared types and constants for the 2-bit saturating-counter branch predictor.
package bp_pkg;

   typedef logic [1:0] bp_state_t;

   localparam bp_state_t BP_SNT   = 2'b00;
   localparam bp_state_t BP_WNT   = 2'b01;
   localparam bp_state_t BP_WT    = 2'b10;
   localparam bp_state_t BP_ST    = 2'b11;
   localparam bp_state_t BP_RESET = BP_WNT;

   localparam int unsigned BP_IDX_W_DEFAULT = 4;
   localparam int unsigned BP_CNT_W_DEFAULT = 32;

endpackage

// File: rtl/branch_predictor_if.sv
// Fetch lookup, ID/EX resolve and statistics signals of the branch predictor.
interface branch_predictor_if
   import bp_pkg::*;
#(
   parameter int unsigned CNT_W = BP_CNT_W_DEFAULT
);

   logic [31:0]      pc;
   logic             branch;
   logic [31:0]      pc_ID_EX;
   logic             branch_ID_EX;
   logic             outcome;
   logic             stall;
   bp_state_t        state;
   logic             mispredict;
   logic [CNT_W-1:0] branch_count;
   logic [CNT_W-1:0] mispredict_count;

   modport master (
      output pc, branch, pc_ID_EX, branch_ID_EX, outcome, stall,
      input  state, mispredict, branch_count, mispredict_count
   );

   modport slave (
      input  pc, branch, pc_ID_EX, branch_ID_EX, outcome, stall,
      output state, mispredict, branch_count, mispredict_count
   );

endinterface

// File: rtl/bp_sat_next.sv
// Saturating 2-bit counter step: count up on taken, down on not-taken.
module bp_sat_next
   import bp_pkg::*;
(
   input  bp_state_t cur,
   input  logic      outcome,
   output bp_state_t nxt
);

   always_comb begin
      nxt = cur;
      if (outcome) begin
         if (cur != BP_ST) nxt = cur + 2'(1);
      end else begin
         if (cur != BP_SNT) nxt = cur - 2'(1);
      end
   end

endmodule

// File: rtl/branch_predictor.sv
// Untagged PC-indexed table of 2-bit counters with saturating statistics.
// Optional macro BP_BYPASS_EN forwards a same-index update to the lookup port.
module branch_predictor
   import bp_pkg::*;
#(
   parameter int unsigned IDX_W = BP_IDX_W_DEFAULT,
   parameter int unsigned CNT_W = BP_CNT_W_DEFAULT
)(
   input logic             clk,
   input logic             reset,
   branch_predictor_if.slave bus
);

   localparam int unsigned ENTRIES = 2 ** IDX_W;
   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

   bp_state_t        entry_q [ENTRIES];
   logic [IDX_W-1:0] rd_idx;
   logic [IDX_W-1:0] wr_idx;
   logic             update_en;
   bp_state_t        cur_entry;
   bp_state_t        nxt_entry;
   bp_state_t        state_c;
   logic             mispredict_c;
   logic [CNT_W-1:0] branch_count_q;
   logic [CNT_W-1:0] mispredict_count_q;
   logic             unused_bits;

   assign rd_idx    = bus.pc[IDX_W+1:2];
   assign wr_idx    = bus.pc_ID_EX[IDX_W+1:2];
   assign update_en = bus.branch_ID_EX & ~bus.stall;
   assign cur_entry = entry_q[wr_idx];

   // Only the index bits of the PCs matter; lookup ignores the branch flag.
   assign unused_bits = ^{bus.branch, bus.pc[31:IDX_W+2], bus.pc[1:0],
                          bus.pc_ID_EX[31:IDX_W+2], bus.pc_ID_EX[1:0]};

   bp_sat_next u_sat_next (
      .cur     (cur_entry),
      .outcome (bus.outcome),
      .nxt     (nxt_entry)
   );

   always_comb begin
      state_c = entry_q[rd_idx];
`ifdef BP_BYPASS_EN
      if (update_en && (rd_idx == wr_idx)) state_c = nxt_entry;
`endif
   end

   // Compares against the pre-update entry; quiet during stall and reset.
   assign mispredict_c = update_en & ~reset & (cur_entry[1] != bus.outcome);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int unsigned i = 0; i < ENTRIES; i++) entry_q[i] <= BP_RESET;
      end else if (update_en) begin
         entry_q[wr_idx] <= nxt_entry;
      end
   end

   // Statistics counters stick at all-ones instead of wrapping.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         branch_count_q     <= '0;
         mispredict_count_q <= '0;
      end else if (update_en) begin
         if (branch_count_q != CNT_MAX)
            branch_count_q <= branch_count_q + CNT_W'(1);
         if (mispredict_c && (mispredict_count_q != CNT_MAX))
            mispredict_count_q <= mispredict_count_q + CNT_W'(1);
      end
   end

   assign bus.state            = state_c;
   assign bus.mispredict       = mispredict_c;
   assign bus.branch_count     = branch_count_q;
   assign bus.mispredict_count = mispredict_count_q;

endmodule

// File: tb/tb_branch_predictor.sv
// Directed self-checking bench for branch_predictor (IDX_W=4, CNT_W=4).
module tb_branch_predictor;

   logic clk = 1'b0;
   logic reset = 1'b1;
   int   total = 0;
   int   bad = 0;

   branch_predictor_if #(.CNT_W(4)) bus ();

   branch_predictor #(.IDX_W(4), .CNT_W(4)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.slave)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      bus.branch_ID_EX = 1'b0;
      bus.stall        = 1'b0;
      bus.outcome      = 1'b0;
   endtask

   task automatic test_reset();
      bus.pc = 32'h0; bus.branch = 1'b0; bus.pc_ID_EX = 32'h0;
      idle();
      reset = 1'b1;
      step(); step();
      total++; if (bus.state !== 2'b01) begin bad++; $display("FAIL reset_state got=%b exp=01", bus.state); end
      total++; if (bus.branch_count !== 4'd0) begin bad++; $display("FAIL reset_bcnt got=%0d exp=0", bus.branch_count); end
      total++; if (bus.mispredict_count !== 4'd0) begin bad++; $display("FAIL reset_mcnt got=%0d exp=0", bus.mispredict_count); end
      bus.pc = 32'h3C; #1;
      total++; if (bus.state !== 2'b01) begin bad++; $display("FAIL reset_state_3c got=%b exp=01", bus.state); end
      reset = 1'b0;
      step();
   endtask

   task automatic test_train();
      logic [1:0] exp_state [3] = '{2'b10, 2'b11, 2'b11};
      logic       exp_mis   [3] = '{1'b1, 1'b0, 1'b0};
      bus.pc = 32'h10; bus.pc_ID_EX = 32'h10; #1;
      total++; if (bus.state !== 2'b01) begin bad++; $display("FAIL train_init got=%b exp=01", bus.state); end
      for (int i = 0; i < 3; i++) begin
         bus.branch_ID_EX = 1'b1; bus.outcome = 1'b1; #1;
         total++; if (bus.mispredict !== exp_mis[i]) begin bad++; $display("FAIL train_mis%0d got=%b exp=%b", i, bus.mispredict, exp_mis[i]); end
         step();
         idle(); #1;
         total++; if (bus.state !== exp_state[i]) begin bad++; $display("FAIL train_state%0d got=%b exp=%b", i, bus.state, exp_state[i]); end
      end
      total++; if (bus.branch_count !== 4'd3) begin bad++; $display("FAIL train_bcnt got=%0d exp=3", bus.branch_count); end
      total++; if (bus.mispredict_count !== 4'd1) begin bad++; $display("FAIL train_mcnt got=%0d exp=1", bus.mispredict_count); end
   endtask

   task automatic test_stall();
      bus.pc = 32'h10; bus.pc_ID_EX = 32'h10;
      bus.branch_ID_EX = 1'b1; bus.outcome = 1'b0; bus.stall = 1'b1;
      for (int i = 0; i < 2; i++) begin
         #1;
         total++; if (bus.mispredict !== 1'b0) begin bad++; $display("FAIL stall_mis%0d got=%b exp=0", i, bus.mispredict); end
         step();
         total++; if (bus.state !== 2'b11) begin bad++; $display("FAIL stall_state%0d got=%b exp=11", i, bus.state); end
      end
      total++; if (bus.branch_count !== 4'd3) begin bad++; $display("FAIL stall_bcnt got=%0d exp=3", bus.branch_count); end
      total++; if (bus.mispredict_count !== 4'd1) begin bad++; $display("FAIL stall_mcnt got=%0d exp=1", bus.mispredict_count); end
      idle();
   endtask

   task automatic test_bypass();
      logic [1:0] exp_same;
`ifdef BP_BYPASS_EN
      exp_same = 2'b10;
`else
      exp_same = 2'b01;
`endif
      bus.pc = 32'h24; bus.pc_ID_EX = 32'h24;
      bus.branch_ID_EX = 1'b1; bus.outcome = 1'b1; #1;
      total++; if (bus.state !== exp_same) begin bad++; $display("FAIL bypass_same got=%b exp=%b", bus.state, exp_same); end
      step();
      idle(); #1;
      total++; if (bus.state !== 2'b10) begin bad++; $display("FAIL bypass_next got=%b exp=10", bus.state); end
   endtask

   task automatic test_alias();
      bus.pc = 32'h44; bus.pc_ID_EX = 32'h04;
      bus.branch_ID_EX = 1'b1; bus.outcome = 1'b1;
      step();
      idle(); #1;
      total++; if (bus.state !== 2'b10) begin bad++; $display("FAIL alias_44 got=%b exp=10", bus.state); end
      bus.pc = 32'h04; #1;
      total++; if (bus.state !== 2'b10) begin bad++; $display("FAIL alias_04 got=%b exp=10", bus.state); end
      total++; if (bus.branch_count !== 4'd5) begin bad++; $display("FAIL alias_bcnt got=%0d exp=5", bus.branch_count); end
      total++; if (bus.mispredict_count !== 4'd3) begin bad++; $display("FAIL alias_mcnt got=%0d exp=3", bus.mispredict_count); end
   endtask

   task automatic test_saturate();
      // Entry 0x08 goes 01->10->11..: one mispredict, then 10 more hits -> bcnt 15.
      bus.pc_ID_EX = 32'h08; bus.branch_ID_EX = 1'b1; bus.outcome = 1'b1;
      for (int i = 0; i < 10; i++) step();
      #1;
      total++; if (bus.branch_count !== 4'd15) begin bad++; $display("FAIL sat_bcnt_max got=%0d exp=15", bus.branch_count); end
      step();
      total++; if (bus.branch_count !== 4'd15) begin bad++; $display("FAIL sat_bcnt_hold got=%0d exp=15", bus.branch_count); end
      total++; if (bus.mispredict_count !== 4'd4) begin bad++; $display("FAIL sat_mcnt got=%0d exp=4", bus.mispredict_count); end
      // Alternating outcomes on 0x0C mispredict every time: 4 + 12 saturates at 15.
      bus.pc_ID_EX = 32'h0C;
      for (int i = 0; i < 12; i++) begin
         bus.outcome = ~i[0];
         step();
      end
      total++; if (bus.mispredict_count !== 4'd15) begin bad++; $display("FAIL sat_mcnt_max got=%0d exp=15", bus.mispredict_count); end
      total++; if (bus.branch_count !== 4'd15) begin bad++; $display("FAIL sat_bcnt_end got=%0d exp=15", bus.branch_count); end
      idle();
   endtask

   task automatic test_reset_mid();
      bus.pc = 32'h10; bus.pc_ID_EX = 32'h10;
      bus.branch_ID_EX = 1'b1; bus.outcome = 1'b0;
      @(negedge clk); #2;
      reset = 1'b1; #1;
      total++; if (bus.state !== 2'b01) begin bad++; $display("FAIL rmid_state got=%b exp=01", bus.state); end
      total++; if (bus.branch_count !== 4'd0) begin bad++; $display("FAIL rmid_bcnt got=%0d exp=0", bus.branch_count); end
      total++; if (bus.mispredict_count !== 4'd0) begin bad++; $display("FAIL rmid_mcnt got=%0d exp=0", bus.mispredict_count); end
      total++; if (bus.mispredict !== 1'b0) begin bad++; $display("FAIL rmid_mis got=%b exp=0", bus.mispredict); end
      step();
      total++; if (bus.state !== 2'b01) begin bad++; $display("FAIL rmid_held got=%b exp=01", bus.state); end
      reset = 1'b0;
      step();
      total++; if (bus.state !== 2'b00) begin bad++; $display("FAIL rmid_first got=%b exp=00", bus.state); end
      total++; if (bus.branch_count !== 4'd1) begin bad++; $display("FAIL rmid_first_bcnt got=%0d exp=1", bus.branch_count); end
      step();
      total++; if (bus.state !== 2'b00) begin bad++; $display("FAIL rmid_floor got=%b exp=00", bus.state); end
      total++; if (bus.mispredict_count !== 4'd0) begin bad++; $display("FAIL rmid_floor_mcnt got=%0d exp=0", bus.mispredict_count); end
      idle();
   endtask

   initial begin
      test_reset();
      test_train();
      test_stall();
      test_bypass();
      test_alias();
      test_saturate();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/branch_predictor.md
BRANCH_PREDICTOR -- requirements
Module: branch_predictor

Interface
REQ-001 Parameter IDX_W, default 4, SHALL set the table index width; the table SHALL hold 2**IDX_W entries.
REQ-002 Parameter CNT_W, default 32, SHALL set the width of the statistics counters.
REQ-003 Port clk, input, 1: single clock; all state SHALL update on its rising edge.
REQ-004 Port reset, input, 1: reset SHALL be asynchronous and active-high.
REQ-005 Port pc, input, 32: fetch-stage PC used for lookup.
REQ-006 Port branch, input, 1: fetch-stage instruction is a conditional branch.
REQ-007 Port pc_ID_EX, input, 32: PC of the resolving branch in ID/EX.
REQ-008 Port branch_ID_EX, input, 1: ID/EX holds a conditional branch being resolved.
REQ-009 Port outcome, input, 1: resolved direction, where 1 means taken.
REQ-010 Port stall, input, 1: pipeline stall; while it is high the table and counters SHALL be frozen.
REQ-011 Port state, output, 2: counter value for pc; state[1] is the taken prediction consumed by fetch.
REQ-012 Port mispredict, output, 1: the resolving branch disagreed with its table entry.
REQ-013 Port branch_count, output, CNT_W: number of resolved branches.
REQ-014 Port mispredict_count, output, CNT_W: number of mispredicted branches.

Function
REQ-015 Encoding SHALL be 2'b00 strongly-not-taken, 2'b01 weakly-not-taken, 2'b10 weakly-taken, 2'b11 strongly-taken.
REQ-016 Lookup index SHALL be pc[IDX_W+1:2], and state SHALL be combinational from the table with zero-cycle latency, independent of branch.
REQ-017 Update index SHALL be pc_ID_EX[IDX_W+1:2], and an update SHALL occur only when branch_ID_EX=1 and stall=0.
REQ-018 On update with outcome=1, the entry SHALL increment and saturate at 2'b11.
REQ-019 On update with outcome=0, the entry SHALL decrement and saturate at 2'b00.
REQ-020 The new entry value SHALL be written at the clock edge, so it is visible on state from the next cycle.
REQ-021 mispredict SHALL be combinational: branch_ID_EX & (entry[update index][1] != outcome), using the pre-update value; it SHALL be gated low when stall=1.
REQ-022 branch_count SHALL increment by 1 on every update.
REQ-023 mispredict_count SHALL increment by 1 on every update where mispredict=1.
REQ-024 Both counters SHALL saturate at all-ones and never wrap.
REQ-025 When the lookup index and update index are equal in the same cycle, state SHALL show the pre-update value unless BP_BYPASS_EN is defined (REQ-029).
REQ-026 Indices SHALL alias by PC bits; no tags are kept.

Reset
REQ-027 While reset=1, every table entry SHALL be 2'b01, both counters SHALL be 0, and state SHALL show 2'b01 for any pc.
REQ-028 Reset asserted mid-update SHALL discard the update; the first update SHALL occur on the first rising edge after reset deasserts.

Configuration
REQ-029 With macro BP_BYPASS_EN defined, on an index match during an update cycle (REQ-017), state SHALL show the post-update value combinationally.
REQ-030 Without BP_BYPASS_EN, no bypass path SHALL exist and REQ-025 applies.

Structure
REQ-031 Package bp_pkg SHALL hold the 2-bit state typedef, the four encoding constants, the reset value 2'b01 and the default IDX_W and CNT_W.
REQ-032 Sub-module bp_sat_next SHALL compute the saturating 2-bit next value from the current value and outcome; the table SHALL instantiate it once on the update path.

Verification
REQ-033 Reset, then pc=0x00 -> state=2'b01; branch_count=0; mispredict_count=0.
REQ-034 Three updates with pc_ID_EX=0x10 and outcome=1 -> state for pc=0x10 SHALL go 01->10->11->11; mispredict=1 on the first update only; mispredict_count=1.
REQ-035 Entry 0x10 at 2'b11, then pc_ID_EX=0x10 with outcome=0 and stall=1 for 2 cycles -> entry SHALL stay 11, counters SHALL be unchanged, and mispredict=0.
REQ-036 pc=pc_ID_EX=0x24 with entry 2'b01 and outcome=1 -> same-cycle state SHALL be 01 without BP_BYPASS_EN and 10 with it; the next cycle SHALL show 10 in both builds.
REQ-037 Aliasing: update pc_ID_EX=0x04 to taken -> lookup pc=0x44 (IDX_W=4) SHALL show the same value.
REQ-038 Force branch_count to all-ones, then one more update -> branch_count SHALL stay all-ones; assert reset mid-cycle -> all outputs SHALL return to reset values immediately.
